ctrl_src_arbiter: RTL and testbench

Decides which control source owns the clock/sensor controls: PC (UART-decoded commands) or FPGA (debounced board buttons/switches). Drives the select input of the PC/FPGA control mux. Also drives a blanking strobe that the top level ANDs onto the muxed button pulses, so no pulse leaks through during a hand-over. Local FPGA activity always has priority; PC ownership expires after an idle timeout.

---
 rtl/ctrl_arb_pkg.sv | 17 +
 rtl/arb_ms_timer.sv | 41 ++++
 rtl/ctrl_src_arbiter.sv | 151 +++++++++++++++
 tb/tb_ctrl_src_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_arb_pkg.sv
// Shared types for the PC/FPGA control-source arbiter.
// State encoding plus the clock-to-millisecond divider helper.
package ctrl_arb_pkg;

    typedef enum logic [1:0] {
        FPGA_OWN      = 2'd0,
        GUARD_TO_PC   = 2'd1,
        PC_OWN        = 2'd2,
        GUARD_TO_FPGA = 2'd3
    } arbState_t;

    // Cycles per millisecond, never below 1 so very slow sim clocks still tick.
    function automatic int msDiv(input int clkHz);
        return (clkHz / 1000 < 1) ? 1 : clkHz / 1000;
    endfunction

endpackage

// File: rtl/arb_ms_timer.sv
// PC idle timer: 1 ms prescaler feeding a saturating ms counter, synchronous clear.
// oExpire is combinational and asserts on the tick that makes the count reach TIMEOUT_MS (0 disables).
module arb_ms_timer #(
    parameter int MS_DIV     = 100_000,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic iClk,
    input  logic iRsn,
    input  logic iClr,
    output logic oExpire
);

    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int MW = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;

    logic [PW-1:0] prescCnt;
    logic [MW-1:0] msCnt;
    logic          msTick;

    assign msTick = (prescCnt == PW'(MS_DIV - 1));

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            prescCnt <= '0;
            msCnt    <= '0;
        end else if (iClr) begin
            prescCnt <= '0;
            msCnt    <= '0;
        end else begin
            prescCnt <= msTick ? '0 : prescCnt + PW'(1);
            if (msTick && msCnt != MW'(TIMEOUT_MS))
                msCnt <= msCnt + MW'(1);
        end
    end

    // Look ahead one tick so the owner FSM reacts on the very edge the count lands.
    assign oExpire = (TIMEOUT_MS != 0) && !iClr &&
                     ((msCnt == MW'(TIMEOUT_MS)) ||
                      (msTick && msCnt == MW'(TIMEOUT_MS - 1)));

endmodule

// File: rtl/ctrl_src_arbiter.sv
// Selects PC or FPGA as owner of clock/sensor controls, blanking pulses for GUARD_CYC cycles on hand-over.
// Registered outputs, no backpressure; ARB_STICKY_PC_EN removes the PC idle timeout.
module ctrl_src_arbiter
    import ctrl_arb_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int PC_TIMEOUT_MS = 5000,
    parameter int GUARD_CYC     = 16
) (
    input  logic       iClk,
    input  logic       iRsn,
    input  logic       iLock,
    input  logic       iPC_Set,
    input  logic [3:0] iPC_Mode,
    input  logic       iPC_Btn_U,
    input  logic       iPC_Btn_D,
    input  logic       iPC_Btn_L,
    input  logic       iPC_Btn_R,
    input  logic       iFPGA_Set,
    input  logic [3:0] iFPGA_Mode,
    input  logic       iFPGA_Btn_U,
    input  logic       iFPGA_Btn_D,
    input  logic       iFPGA_Btn_L,
    input  logic       iFPGA_Btn_R,
    output logic       oSel,
    output logic       oBlank,
    output logic       oOwner_Chg,
    output logic       oTimeout
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    arbState_t     state, nextState;
    logic          armed;
    logic          pcSetQ, fpgaSetQ;
    logic [3:0]    pcModeQ, fpgaModeQ;
    logic          pcAct, fpgaAct;
    logic [GW-1:0] guardCnt;
    logic          guardDone;
    logic          timerExpire;
    logic          selNext, blankNext, chgNext, toNext;

    // The first cycle out of reset only seeds history, so held levels are not seen as activity.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            armed     <= 1'b0;
            pcSetQ    <= 1'b0;
            pcModeQ   <= '0;
            fpgaSetQ  <= 1'b0;
            fpgaModeQ <= '0;
        end else begin
            armed     <= 1'b1;
            pcSetQ    <= iPC_Set;
            pcModeQ   <= iPC_Mode;
            fpgaSetQ  <= iFPGA_Set;
            fpgaModeQ <= iFPGA_Mode;
        end
    end

    assign pcAct   = armed & (iPC_Btn_U | iPC_Btn_D | iPC_Btn_L | iPC_Btn_R |
                              (iPC_Set != pcSetQ) | (iPC_Mode != pcModeQ));
    assign fpgaAct = armed & (iFPGA_Btn_U | iFPGA_Btn_D | iFPGA_Btn_L | iFPGA_Btn_R |
                              (iFPGA_Set != fpgaSetQ) | (iFPGA_Mode != fpgaModeQ));

`ifdef ARB_STICKY_PC_EN
    assign timerExpire = 1'b0;
`else
    logic timerClr;
    assign timerClr = (state != PC_OWN) | pcAct;

    arb_ms_timer #(
        .MS_DIV     (msDiv(CLK_HZ)),
        .TIMEOUT_MS (PC_TIMEOUT_MS)
    ) uMsTimer (
        .iClk    (iClk),
        .iRsn    (iRsn),
        .iClr    (timerClr),
        .oExpire (timerExpire)
    );
`endif

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            guardCnt <= '0;
        else if (nextState != state)
            guardCnt <= '0;
        else if (state == GUARD_TO_PC || state == GUARD_TO_FPGA)
            guardCnt <= guardCnt + GW'(1);
        else
            guardCnt <= '0;
    end

    assign guardDone = (guardCnt == GW'(GUARD_CYC - 1));

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            state <= FPGA_OWN;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FPGA_OWN:
                if (pcAct && !fpgaAct && !iLock)
                    nextState = GUARD_TO_PC;
            GUARD_TO_PC:
                if (fpgaAct || iLock)
                    nextState = FPGA_OWN;
                else if (guardDone)
                    nextState = PC_OWN;
            PC_OWN:
                if (fpgaAct || iLock || timerExpire)
                    nextState = GUARD_TO_FPGA;
            GUARD_TO_FPGA:
                if (guardDone)
                    nextState = FPGA_OWN;
            default:
                nextState = FPGA_OWN;
        endcase
    end

    always_comb begin
        selNext   = (nextState == GUARD_TO_PC) || (nextState == PC_OWN);
        blankNext = (nextState == GUARD_TO_PC) || (nextState == GUARD_TO_FPGA);
        chgNext   = ((state == GUARD_TO_PC)   && (nextState == PC_OWN)) ||
                    ((state == GUARD_TO_FPGA) && (nextState == FPGA_OWN));
`ifdef ARB_STICKY_PC_EN
        toNext    = 1'b0;
`else
        toNext    = (state == PC_OWN) && (nextState == GUARD_TO_FPGA) &&
                    !fpgaAct && !iLock;
`endif
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            oSel       <= 1'b0;
            oBlank     <= 1'b0;
            oOwner_Chg <= 1'b0;
            oTimeout   <= 1'b0;
        end else begin
            oSel       <= selNext;
            oBlank     <= blankNext;
            oOwner_Chg <= chgNext;
            oTimeout   <= toNext;
        end
    end

endmodule

// File: tb/tb_ctrl_src_arbiter.sv
// Bench for ctrl_src_arbiter: cycle model of ownership/blank/timeout plus directed literal checks.
module tb_ctrl_src_arbiter;

    localparam int CLK_HZ     = 10_000;
    localparam int TO_MS      = 3;
    localparam int GUARD      = 4;
    localparam int TO_CYCLES  = TO_MS * (CLK_HZ / 1000);

    logic       iClk = 1'b0;
    logic       iRsn = 1'b0;
    logic       iLock = 1'b0;
    logic       iPC_Set = 1'b0;
    logic [3:0] iPC_Mode = 4'h0;
    logic       iPC_Btn_U = 1'b0, iPC_Btn_D = 1'b0, iPC_Btn_L = 1'b0, iPC_Btn_R = 1'b0;
    logic       iFPGA_Set = 1'b0;
    logic [3:0] iFPGA_Mode = 4'h0;
    logic       iFPGA_Btn_U = 1'b0, iFPGA_Btn_D = 1'b0, iFPGA_Btn_L = 1'b0, iFPGA_Btn_R = 1'b0;
    logic       oSel, oBlank, oOwner_Chg, oTimeout;

    int errors = 0;
    int checks = 0;

    ctrl_src_arbiter #(
        .CLK_HZ        (CLK_HZ),
        .PC_TIMEOUT_MS (TO_MS),
        .GUARD_CYC     (GUARD)
    ) dut (
        .iClk        (iClk),
        .iRsn        (iRsn),
        .iLock       (iLock),
        .iPC_Set     (iPC_Set),
        .iPC_Mode    (iPC_Mode),
        .iPC_Btn_U   (iPC_Btn_U),
        .iPC_Btn_D   (iPC_Btn_D),
        .iPC_Btn_L   (iPC_Btn_L),
        .iPC_Btn_R   (iPC_Btn_R),
        .iFPGA_Set   (iFPGA_Set),
        .iFPGA_Mode  (iFPGA_Mode),
        .iFPGA_Btn_U (iFPGA_Btn_U),
        .iFPGA_Btn_D (iFPGA_Btn_D),
        .iFPGA_Btn_L (iFPGA_Btn_L),
        .iFPGA_Btn_R (iFPGA_Btn_R),
        .oSel        (oSel),
        .oBlank      (oBlank),
        .oOwner_Chg  (oOwner_Chg),
        .oTimeout    (oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ownership as (sel, blank) plus a guard countdown and an idle-cycle count.
    logic       mSel = 0, mBlank = 0, mChg = 0, mTo = 0, mArmed = 0;
    int         guardLeft = 0, idle = 0;
    logic       hPcSet = 0, hFpSet = 0;
    logic [3:0] hPcMode = 0, hFpMode = 0;

    always @(posedge iClk) begin
        logic pa, fa;
        if (!iRsn) begin
            mSel = 0; mBlank = 0; mChg = 0; mTo = 0; mArmed = 0;
            hPcSet = 0; hFpSet = 0; hPcMode = 0; hFpMode = 0;
        end else begin
            pa = mArmed && (iPC_Btn_U || iPC_Btn_D || iPC_Btn_L || iPC_Btn_R ||
                            iPC_Set != hPcSet || iPC_Mode != hPcMode);
            fa = mArmed && (iFPGA_Btn_U || iFPGA_Btn_D || iFPGA_Btn_L || iFPGA_Btn_R ||
                            iFPGA_Set != hFpSet || iFPGA_Mode != hFpMode);
            mChg = 0; mTo = 0;
            if (!mSel && !mBlank) begin
                if (pa && !fa && !iLock) begin
                    mSel = 1; mBlank = 1; guardLeft = GUARD;
                end
            end else if (mSel && mBlank) begin
                if (fa || iLock) begin
                    mSel = 0; mBlank = 0;
                end else begin
                    guardLeft--;
                    if (guardLeft == 0) begin
                        mBlank = 0; mChg = 1; idle = 0;
                    end
                end
            end else if (mSel && !mBlank) begin
                if (fa || iLock) begin
                    mSel = 0; mBlank = 1; guardLeft = GUARD;
                end else if (pa) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle == TO_CYCLES) begin
                        mTo = 1; mSel = 0; mBlank = 1; guardLeft = GUARD;
                    end
                end
            end else begin
                guardLeft--;
                if (guardLeft == 0) begin
                    mBlank = 0; mChg = 1;
                end
            end
            hPcSet = iPC_Set; hPcMode = iPC_Mode; hFpSet = iFPGA_Set; hFpMode = iFPGA_Mode;
            mArmed = 1;
        end
        #1;
        chk("model_sel", oSel, mSel);
        chk("model_blank", oBlank, mBlank);
        chk("model_chg", oOwner_Chg, mChg);
        chk("model_timeout", oTimeout, mTo);
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    initial begin
        // 1: reset with a non-zero PC mode held through release
        iPC_Mode = 4'h5;
        waitEdges(3);
        chk("rst_sel", oSel, 1'b0);
        chk("rst_blank", oBlank, 1'b0);
        iRsn = 1'b1;
        waitEdges(10);
        chk("armed_sel", oSel, 1'b0);

        // 2: PC button starts hand-over to PC
        iPC_Btn_U = 1; waitEdges(1); iPC_Btn_U = 0;
        chk("t2_sel_k", oSel, 1'b1);
        chk("t2_blank_k", oBlank, 1'b1);
        waitEdges(4);
        chk("t2_blank_k4", oBlank, 1'b0);
        chk("t2_chg_k4", oOwner_Chg, 1'b1);

        // 3: idle timeout 30 cycles after entry
        waitEdges(1);
        chk("t3_chg_off", oOwner_Chg, 1'b0);
        waitEdges(28);
        chk("t3_to_e29", oTimeout, 1'b0);
        waitEdges(1);
        chk("t3_to_e30", oTimeout, 1'b1);
        chk("t3_sel_e30", oSel, 1'b0);
        chk("t3_blank_e30", oBlank, 1'b1);
        waitEdges(4);
        chk("t3_blank_e34", oBlank, 1'b0);
        chk("t3_chg_e34", oOwner_Chg, 1'b1);

        // 4: periodic PC activity keeps ownership
        iPC_Btn_U = 1; waitEdges(1); iPC_Btn_U = 0;
        waitEdges(4);
        chk("t4_enter", oOwner_Chg, 1'b1);
        for (int i = 0; i < 10; i++) begin
            waitEdges(19);
            iPC_Btn_L = 1; waitEdges(1); iPC_Btn_L = 0;
        end
        chk("t4_sel_held", oSel, 1'b1);

        // 5: simultaneous PC+FPGA activity from PC_OWN, then from FPGA_OWN
        iPC_Btn_D = 1; iFPGA_Btn_D = 1; waitEdges(1); iPC_Btn_D = 0; iFPGA_Btn_D = 0;
        chk("t5_pc_sel", oSel, 1'b0);
        chk("t5_pc_blank", oBlank, 1'b1);
        waitEdges(4);
        chk("t5_back_chg", oOwner_Chg, 1'b1);
        iPC_Btn_D = 1; iFPGA_Btn_D = 1; waitEdges(1); iPC_Btn_D = 0; iFPGA_Btn_D = 0;
        chk("t5_fp_sel", oSel, 1'b0);
        chk("t5_fp_blank", oBlank, 1'b0);

        // 6: lock refuses PC, and aborts a guard toward PC
        iLock = 1; waitEdges(1);
        iPC_Btn_R = 1; waitEdges(1); iPC_Btn_R = 0;
        chk("t6_lock_sel", oSel, 1'b0);
        waitEdges(5);
        chk("t6_lock_sel5", oSel, 1'b0);
        iLock = 0; waitEdges(2);
        iPC_Btn_U = 1; waitEdges(1); iPC_Btn_U = 0;
        chk("t6_guard_sel", oSel, 1'b1);
        iLock = 1; waitEdges(1);
        chk("t6_abort_sel", oSel, 1'b0);
        chk("t6_abort_blank", oBlank, 1'b0);
        chk("t6_abort_chg", oOwner_Chg, 1'b0);
        waitEdges(6);
        iLock = 0; waitEdges(2);

        // Level changes count as activity on both sides
        iPC_Mode = 4'h9; waitEdges(1);
        chk("lvl_pc_sel", oSel, 1'b1);
        waitEdges(4);
        iFPGA_Set = 1; waitEdges(1);
        chk("lvl_fp_sel", oSel, 1'b0);
        chk("lvl_fp_blank", oBlank, 1'b1);
        waitEdges(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
